// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage sitting directly upstream of the register file.
// It decodes one MIPS instruction per handshake and drives the register-file
// read ports. Writeback data arriving in the same cycle is bypassed into the
// operands. A per-register pending-write scoreboard stalls RAW/WAW hazards.
// Operands, the sign-extended immediate and destination info are registered
// into a single valid/ready output stage that feeds execute.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   Once Out_Valid is 1, every Out_* stays stable until Out_Ready is seen.
//   In_Ready never depends on In_Valid except through the hazard term. An
//   instruction that is not valid cannot create a hazard.
module operand_fetch #(
  parameter int D_WIDTH  = 32,
  parameter int RA_WIDTH = 5
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                In_Valid,
  output logic                In_Ready,
  input  logic [31:0]         Instr,
  output logic [RA_WIDTH-1:0] R1_Addr,
  output logic [RA_WIDTH-1:0] R2_Addr,
  output logic                R1_en,
  output logic                R2_en,
  input  logic [D_WIDTH-1:0]  R1_Data,
  input  logic [D_WIDTH-1:0]  R2_Data,
  input  logic                WB_en,
  input  logic [RA_WIDTH-1:0] WB_Addr,
  input  logic [D_WIDTH-1:0]  WB_Data,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic [D_WIDTH-1:0]  Out_Rs_Data,
  output logic [D_WIDTH-1:0]  Out_Rt_Data,
  output logic [D_WIDTH-1:0]  Out_Imm,
  output logic [RA_WIDTH-1:0] Out_Dst,
  output logic                Out_Wr,
  output logic [31:0]         Out_Instr
);

  localparam int NREG = 1 << RA_WIDTH;

  // Instruction classes that matter to this stage.
  typedef enum logic [1:0] {
    CLS_NONE    = 2'd0,  // no reads, no write
    CLS_RTYPE   = 2'd1,  // reads rs, rt; writes rd
    CLS_IMM_WR  = 2'd2,  // reads rs; writes rt (addi/andi/ori/lw)
    CLS_RD_ONLY = 2'd3   // reads rs, rt; no write (sw/beq)
  } cls_e;

  logic [5:0]          op;
  logic [RA_WIDTH-1:0] rs_a;
  logic [RA_WIDTH-1:0] rt_a;
  logic [RA_WIDTH-1:0] rd_a;
  cls_e                cls;
  logic                uses_rs;
  logic                uses_rt;
  logic [RA_WIDTH-1:0] dst;
  logic                wr;

  logic                wb_hit_rs;
  logic                wb_hit_rt;
  logic                wb_hit_dst;
  logic                pend_rs;
  logic                pend_rt;
  logic                pend_dst;
  logic                hazard;
  logic                in_ready;
  logic                accept;

  logic [D_WIDTH-1:0]  rs_data;
  logic [D_WIDTH-1:0]  rt_data;
  logic [D_WIDTH-1:0]  imm_ext;

  logic [NREG-1:0]     sb_q;
  logic [NREG-1:0]     sb_d;

  logic                out_valid_q;
  logic [D_WIDTH-1:0]  rs_q;
  logic [D_WIDTH-1:0]  rt_q;
  logic [D_WIDTH-1:0]  imm_q;
  logic [RA_WIDTH-1:0] dst_q;
  logic                wr_q;
  logic [31:0]         instr_q;

  assign op   = Instr[31:26];
  assign rs_a = RA_WIDTH'(Instr[25:21]);
  assign rt_a = RA_WIDTH'(Instr[20:16]);
  assign rd_a = RA_WIDTH'(Instr[15:11]);

  // Classify the opcode and derive source usage and destination.
  // Non-writing classes report destination 0, so Out_Dst is only meaningful with Out_Wr.
  always_comb begin
    cls = CLS_NONE;
    case (op)
      6'h00:                      cls = CLS_RTYPE;
      6'h08, 6'h0C, 6'h0D, 6'h23: cls = CLS_IMM_WR;
      6'h2B, 6'h04:               cls = CLS_RD_ONLY;
      default:                    cls = CLS_NONE;
    endcase
    uses_rs = (cls != CLS_NONE);
    uses_rt = (cls == CLS_RTYPE) || (cls == CLS_RD_ONLY);
    dst     = '0;
    if (cls == CLS_RTYPE)  dst = rd_a;
    if (cls == CLS_IMM_WR) dst = rt_a;
    wr      = (dst != '0);
  end

  // Hazard detection against the scoreboard, with same-cycle writeback treated as resolved.
  always_comb begin
    wb_hit_rs  = WB_en && (WB_Addr == rs_a);
    wb_hit_rt  = WB_en && (WB_Addr == rt_a);
    wb_hit_dst = WB_en && (WB_Addr == dst);
    pend_rs    = sb_q[rs_a] && !wb_hit_rs;
    pend_rt    = sb_q[rt_a] && !wb_hit_rt;
    pend_dst   = sb_q[dst]  && !wb_hit_dst;
    hazard     = In_Valid && ((uses_rs && pend_rs) || (uses_rt && pend_rt) || (wr && pend_dst));
    in_ready   = Rst && (!out_valid_q || Out_Ready) && !hazard;
    accept     = In_Valid && in_ready;
  end

  // Operand select: $0 or unused port gives zero, else bypass, else register file.
  always_comb begin
    rs_data = R1_Data;
    if (!uses_rs || (rs_a == '0)) rs_data = '0;
    else if (wb_hit_rs)           rs_data = WB_Data;
    rt_data = R2_Data;
    if (!uses_rt || (rt_a == '0)) rt_data = '0;
    else if (wb_hit_rt)           rt_data = WB_Data;
    imm_ext = {{(D_WIDTH-16){Instr[15]}}, Instr[15:0]};
  end

  // Scoreboard next state: writeback clears first, then an accepted write sets (set wins).
  always_comb begin
    sb_d = sb_q;
    if (WB_en)         sb_d[WB_Addr] = 1'b0;
    if (accept && wr)  sb_d[dst]     = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Output stage and scoreboard registers; reset discards any pending output.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sb_q        <= '0;
      out_valid_q <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      dst_q       <= '0;
      wr_q        <= 1'b0;
      instr_q     <= '0;
    end else begin
      sb_q <= sb_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        rs_q        <= rs_data;
        rt_q        <= rt_data;
        imm_q       <= imm_ext;
        dst_q       <= dst;
        wr_q        <= wr;
        instr_q     <= Instr;
      end else if (Out_Ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign In_Ready    = in_ready;
  assign R1_Addr     = rs_a;
  assign R2_Addr     = rt_a;
  assign R1_en       = In_Valid && uses_rs;
  assign R2_en       = In_Valid && uses_rt;
  assign Out_Valid   = out_valid_q;
  assign Out_Rs_Data = rs_q;
  assign Out_Rt_Data = rt_q;
  assign Out_Imm     = imm_q;
  assign Out_Dst     = dst_q;
  assign Out_Wr      = wr_q;
  assign Out_Instr   = instr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a register-file model drives the read data. A
// transaction-level reference model predicts In_Ready and pending registers,
// and a queue holds the expected output-stage transactions.
module tb_operand_fetch;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 3*DW + AW + 1 + 32;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic wb_en = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic out_ready = 1'b0;

  logic in_ready, r1_en, r2_en, out_valid, out_wr;
  logic [AW-1:0] r1_addr, r2_addr, out_dst;
  logic [DW-1:0] r1_data, r2_data, out_rs, out_rt, out_imm;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  // Register-file model: combinational read, garbage on a disabled port.
  logic [DW-1:0] rf [32];
  assign r1_data = r1_en ? rf[r1_addr] : 32'hBAD0BAD0;
  assign r2_data = r2_en ? rf[r2_addr] : 32'hBAD1BAD1;

  operand_fetch #(.D_WIDTH(DW), .RA_WIDTH(AW)) dut (
    .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(in_ready), .Instr(instr),
    .R1_Addr(r1_addr), .R2_Addr(r2_addr), .R1_en(r1_en), .R2_en(r2_en),
    .R1_Data(r1_data), .R2_Data(r2_data),
    .WB_en(wb_en), .WB_Addr(wb_addr), .WB_Data(wb_data),
    .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Out_Rs_Data(out_rs), .Out_Rt_Data(out_rt), .Out_Imm(out_imm),
    .Out_Dst(out_dst), .Out_Wr(out_wr), .Out_Instr(out_instr)
  );

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] busy = '0;         // registers with an outstanding write
  logic m_valid = 1'b0;           // output stage holds a transaction
  logic [OW-1:0] exp_q[$];        // expected output transactions

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction classes as stated for the stage.
  function automatic void decode(input logic [31:0] ins, output bit urs, output bit urt,
                                 output bit wr, output logic [4:0] dst);
    bit w;
    urs = 0; urt = 0; w = 0; dst = '0;
    case (ins[31:26])
      6'h00: begin urs = 1; urt = 1; w = 1; dst = ins[15:11]; end
      6'h08, 6'h0C, 6'h0D, 6'h23: begin urs = 1; w = 1; dst = ins[20:16]; end
      6'h2B, 6'h04: begin urs = 1; urt = 1; end
      default: ;
    endcase
    wr = w && (dst != 0);
    if (!wr) dst = '0;
  endfunction

  function automatic bit pend(input logic [4:0] r);
    return busy[r] && !(wb_en && wb_addr == r);
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r, input bit used);
    if (!used || r == 0) return '0;
    if (wb_en && wb_addr == r) return wb_data;
    return rf[r];
  endfunction

  task automatic check_out();
    logic [31:0] e_rs, e_rt, e_imm, e_ins;
    logic [4:0] e_dst;
    logic e_wr;
    chk("out_valid", out_valid, m_valid);
    if (m_valid && exp_q.size() > 0) begin
      {e_rs, e_rt, e_imm, e_dst, e_wr, e_ins} = exp_q[0];
      chk("out_rs", out_rs, e_rs);
      chk("out_rt", out_rt, e_rt);
      chk("out_imm", out_imm, e_imm);
      chk("out_dst", out_dst, e_dst);
      chk("out_wr", out_wr, e_wr);
      chk("out_instr", out_instr, e_ins);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_rs"}, out_rs, 0);
    chk({tag, "_rt"}, out_rt, 0);
    chk({tag, "_imm"}, out_imm, 0);
    chk({tag, "_dst"}, out_dst, 0);
    chk({tag, "_wr"}, out_wr, 0);
    chk({tag, "_instr"}, out_instr, 0);
    chk({tag, "_sb"}, dut.sb_q, 0);
  endtask

  // One clock: called at a falling edge with inputs already driven.
  task automatic cycle();
    bit urs, urt, wr, hz, exp_rdy, acc;
    logic [4:0] dst, rs, rt;
    logic [31:0] rsv, rtv, imm;
    #1;
    decode(instr, urs, urt, wr, dst);
    rs = instr[25:21];
    rt = instr[20:16];
    hz = in_valid && ((urs && pend(rs)) || (urt && pend(rt)) || (wr && pend(dst)));
    exp_rdy = rst && (!m_valid || out_ready) && !hz;
    chk("in_ready", in_ready, exp_rdy);
    chk("r1_en", r1_en, in_valid && urs);
    chk("r2_en", r2_en, in_valid && urt);
    if (in_valid && urs) chk("r1_addr", r1_addr, rs);
    if (in_valid && urt) chk("r2_addr", r2_addr, rt);
    acc = in_valid && exp_rdy;
    rsv = opnd(rs, urs);
    rtv = opnd(rt, urt);
    imm = {{16{instr[15]}}, instr[15:0]};
    @(posedge clk);
    #1;
    if (!rst) begin
      busy = '0;
      m_valid = 0;
      exp_q.delete();
    end else begin
      if (m_valid && out_ready) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({rsv, rtv, imm, dst, wr, instr});
      m_valid = acc || (m_valid && !out_ready);
      if (wb_en) busy[wb_addr] = 1'b0;
      if (acc && wr) busy[dst] = 1'b1;
      busy[0] = 1'b0;
    end
    if (wb_en && wb_addr != 0) rf[wb_addr] = wb_data;
    chk("sb", dut.sb_q, busy);
    @(negedge clk);
    check_out();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [31:0] ins, input logic wbe,
                       input logic [4:0] wba, input logic [31:0] wbd, input logic ordy);
    in_valid = iv; instr = ins; wb_en = wbe; wb_addr = wba; wb_data = wbd; out_ready = ordy;
  endtask

  task automatic rf_init();
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = '0;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic [31:0] rs, rt, imm;
    logic [4:0]  dst;
    logic        wr;
  } vec_t;

  vec_t vt[9];
  logic [31:0] snap_rs, snap_rt, snap_imm, snap_ins;
  logic [4:0] snap_dst;
  logic [5:0] ops[8];

  initial begin
    vt[0] = '{32'h00221820, 0, 0, 0, 32'h1001, 32'h1002, 32'h00001820, 3, 1};     // add $3,$1,$2
    vt[1] = '{32'h20640001, 0, 0, 0, 32'h1003, 32'h0, 32'h1, 4, 1};              // addi $4,$3,1
    vt[2] = '{32'h3405FFFF, 0, 0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 5, 1};           // ori $5,$0,-1
    vt[3] = '{32'hAC470008, 0, 0, 0, 32'h1002, 32'h1007, 32'h8, 0, 0};            // sw
    vt[4] = '{32'h1022FFFF, 0, 0, 0, 32'h1001, 32'h1002, 32'hFFFFFFFF, 0, 0};     // beq
    vt[5] = '{32'h08000010, 0, 0, 0, 32'h0, 32'h0, 32'h10, 0, 0};                 // j: no reads
    vt[6] = '{32'h8D498000, 0, 0, 0, 32'h100A, 32'h0, 32'hFFFF8000, 9, 1};        // lw
    vt[7] = '{32'h310600F0, 1, 8, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'hF0, 6, 1}; // andi, bypass
    vt[8] = '{32'h00430022, 0, 0, 0, 32'h1002, 32'h1003, 32'h22, 0, 0};           // sub $0: no write
    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};

    rf_init();
    @(negedge clk);

    // Reset held 2 cycles with an instruction offered.
    rst = 0;
    drive(1, 32'h0, 0, 0, 0, 1);
    cycle();
    cycle();
    check_zero("reset");
    rst = 1;
    #1 chk("ready_after_reset", in_ready, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 1);
    cycle();

    // Table of single instructions, each from a clean state.
    for (int i = 0; i < 9; i++) begin
      rf_init();
      drive(1, vt[i].ins, vt[i].wbe, vt[i].wba, vt[i].wbd, 1);
      cycle();
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_rs", i), out_rs, vt[i].rs);
      chk($sformatf("tbl%0d_rt", i), out_rt, vt[i].rt);
      chk($sformatf("tbl%0d_imm", i), out_imm, vt[i].imm);
      chk($sformatf("tbl%0d_dst", i), out_dst, vt[i].dst);
      chk($sformatf("tbl%0d_wr", i), out_wr, vt[i].wr);
      drive(0, 0, vt[i].wr, vt[i].dst, rf[vt[i].dst], 1);
      cycle();
    end

    // add $3,$1,$2 with read data 5 and 7.
    rf_init();
    rf[1] = 5; rf[2] = 7;
    drive(1, 32'h00221820, 0, 0, 0, 1);
    #1;
    chk("add_r1_addr", r1_addr, 1);
    chk("add_r2_addr", r2_addr, 2);
    chk("add_r1_en", r1_en, 1);
    chk("add_r2_en", r2_en, 1);
    cycle();
    chk("add_valid", out_valid, 1);
    chk("add_rs", out_rs, 5);
    chk("add_rt", out_rt, 7);
    chk("add_dst", out_dst, 3);
    chk("add_wr", out_wr, 1);
    chk("add_sb3", dut.sb_q[3], 1);

    // addi $4,$3,1 stalls until $3 writes back, then takes the bypassed value.
    drive(1, 32'h20640001, 0, 0, 0, 1);
    #1 chk("raw_stall1", in_ready, 0);
    cycle();
    #1 chk("raw_stall2", in_ready, 0);
    cycle();
    drive(1, 32'h20640001, 1, 3, 12, 1);
    #1 chk("raw_release", in_ready, 1);
    cycle();
    chk("addi_rs", out_rs, 12);
    chk("addi_imm", out_imm, 1);
    chk("addi_dst", out_dst, 4);
    chk("addi_sb3", dut.sb_q[3], 0);
    chk("addi_sb4", dut.sb_q[4], 1);

    // Backpressure: output held for 3 cycles while a new instruction waits.
    snap_rs = out_rs; snap_rt = out_rt; snap_imm = out_imm; snap_dst = out_dst; snap_ins = out_instr;
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h34070005, 0, 0, 0, 0);
      #1 chk("bp_ready", in_ready, 0);
      cycle();
      chk("bp_valid", out_valid, 1);
      chk("bp_rs_hold", out_rs, snap_rs);
      chk("bp_rt_hold", out_rt, snap_rt);
      chk("bp_imm_hold", out_imm, snap_imm);
      chk("bp_dst_hold", out_dst, snap_dst);
      chk("bp_instr_hold", out_instr, snap_ins);
    end
    drive(1, 32'h34070005, 0, 0, 0, 1);
    #1 chk("bp_release", in_ready, 1);
    cycle();
    chk("bp_new_instr", out_instr, 32'h34070005);
    chk("bp_new_imm", out_imm, 5);
    chk("bp_new_dst", out_dst, 7);

    // $0 with a writeback to $0 in the same cycle.
    drive(1, 32'h00000020, 1, 0, 99, 1);
    #1 chk("zero_ready", in_ready, 1);
    cycle();
    chk("zero_rs", out_rs, 0);
    chk("zero_rt", out_rt, 0);
    chk("zero_wr", out_wr, 0);
    chk("zero_sb", dut.sb_q, 32'h00000090);

    // Set/clear collision on $5.
    drive(1, 32'h34051234, 0, 0, 0, 1);
    cycle();
    chk("coll_pre_sb5", dut.sb_q[5], 1);
    drive(1, 32'h8CC5FFFC, 1, 5, 32'h55, 1);
    #1 chk("coll_ready", in_ready, 1);
    cycle();
    chk("coll_sb5", dut.sb_q[5], 1);
    chk("coll_imm", out_imm, 32'hFFFFFFFC);
    chk("coll_dst", out_dst, 5);
    chk("coll_rs", out_rs, 32'h1006);
    drive(0, 0, 1, 4, rf[4], 1); cycle();
    drive(0, 0, 1, 5, rf[5], 1); cycle();
    drive(0, 0, 1, 7, rf[7], 1); cycle();

    // Reset while an output is pending: dropped, never replayed.
    drive(1, 32'h00221820, 0, 0, 0, 0);
    cycle();
    chk("mid_pending", out_valid, 1);
    rst = 0;
    cycle();
    check_zero("mid_reset");
    rst = 1;
    drive(0, 0, 0, 0, 0, 1);
    cycle();
    chk("mid_no_replay", out_valid, 0);

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] r;
      logic [31:0] ins;
      ins = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 11'($urandom)};
      wb_en = 0; wb_addr = '0;
      if (busy != 0 && $urandom_range(0, 1) == 1) begin
        for (int t = 0; t < 20 && !wb_en; t++) begin
          r = 5'($urandom_range(1, 7));
          if (busy[r]) begin wb_en = 1; wb_addr = r; end
        end
      end else if ($urandom_range(0, 9) == 0) begin
        wb_en = 1; wb_addr = 5'($urandom_range(0, 7));
      end
      wb_data = $urandom;
      in_valid = ($urandom_range(0, 9) < 8);
      instr = ins;
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch stage directly upstream of the register file.
- Accepts one MIPS instruction per handshake, drives the register-file read ports, and bypasses same-cycle writeback data.
- Tracks pending destination writes in a scoreboard to stall RAW/WAW hazards.
- Registers the operands, sign-extended immediate and destination info into a valid/ready output stage feeding execute.

Parameters:
D_WIDTH, 32, data width (matches register file data width)
RA_WIDTH, 5, register address width; 2**RA_WIDTH registers

Ports:
Clk  in  1  clock, all state on rising edge
Rst  in  1  synchronous, active-low reset (0 = reset)
In_Valid  in  1  upstream instruction valid
In_Ready  out  1  stage can accept instruction this cycle
Instr  in  32  op[31:26] rs[25:21] rt[20:16] rd[15:11] imm[15:0]
R1_Addr  out  RA_WIDTH  register-file read port 1 address (= rs)
R2_Addr  out  RA_WIDTH  register-file read port 2 address (= rt)
R1_en  out  1  read port 1 enable
R2_en  out  1  read port 2 enable
R1_Data  in  D_WIDTH  register-file read data 1 (combinational)
R2_Data  in  D_WIDTH  register-file read data 2 (combinational)
WB_en  in  1  writeback enable (same signal as register-file write enable)
WB_Addr  in  RA_WIDTH  writeback address
WB_Data  in  D_WIDTH  writeback data
Out_Valid  out  1  execute-side operands valid
Out_Ready  in  1  execute accepts
Out_Rs_Data  out  D_WIDTH  rs operand
Out_Rt_Data  out  D_WIDTH  rt operand
Out_Imm  out  D_WIDTH  sign-extended imm[15:0]
Out_Dst  out  RA_WIDTH  destination register
Out_Wr  out  1  instruction writes Out_Dst
Out_Instr  out  32  instruction passed through

Behaviour:
- Decode:
  - op=0x00 (R-type): read rs, rt; dst=rd.
  - op=0x08/0x0C/0x0D/0x23: read rs; dst=rt.
  - op=0x2B, 0x04: read rs, rt; no write.
  - Any other op: no reads, no write.
  - Wr=1 only if the class writes and dst!=0.
- Read enables: R1_en = In_Valid & uses_rs; R2_en = In_Valid & uses_rt. Disabled ports return Z and are never sampled.
- Operand select per source: src==0 or port unused -> 0; WB_en & WB_Addr==src -> WB_Data (bypass); else R*_Data.
- Scoreboard: SB[2**RA_WIDTH] bits; SB[0] is always 0.
  - Pending(r) = SB[r] & ~(WB_en & WB_Addr==r).
- hazard = In_Valid & ((uses_rs & Pending(rs)) | (uses_rt & Pending(rt)) | (Wr & Pending(dst))).
- In_Ready = (~Out_Valid | Out_Ready) & ~hazard. Accept = In_Valid & In_Ready.
- On accept: output registers load the decoded values; Out_Valid<=1. Latency is one cycle, instruction to Out_Valid.
- No accept with Out_Ready=1: Out_Valid<=0.
- Out_Valid=1 with Out_Ready=0: all Out_* held stable.
- Scoreboard update each cycle:
  - Clear SB[WB_Addr] if WB_en.
  - Then set SB[dst] if accept & Wr.
  - Same register set and cleared in one cycle: set wins, SB=1.
- WB_en with WB_Addr=0: bypass never applied to src 0; no scoreboard effect.
- Reset (Rst=0 at a clock edge), including mid-operation:
  - Out_Valid=0, all Out_* = 0, SB all 0.
  - In_Ready=0 while Rst=0.
  - The pending output is discarded and not replayed.

Test Plan:
- Reset: Rst=0 for 2 cycles with In_Valid=1 -> Out_Valid=0, Out_* all 0, In_Ready=0; after Rst=1 -> In_Ready=1.
- add $3,$1,$2 (0x00221820) with R1_Data=5, R2_Data=7, Out_Ready=1 -> R1_Addr=1, R2_Addr=2, both enables 1. Next cycle: Out_Valid=1, Rs=5, Rt=7, Dst=3, Wr=1; SB[3]=1.
- addi $4,$3,1 (0x20640001) right after the add -> In_Ready=0 for 2 cycles; the cycle with WB_en=1, WB_Addr=3, WB_Data=12 accepts. Next cycle: Rs=12 (bypassed), Imm=1, Dst=4. SB[3]=0, SB[4]=1.
- Backpressure: Out_Valid=1, Out_Ready=0 for 3 cycles with new In_Valid -> In_Ready=0 and Out_* unchanged. Out_Ready=1 -> the new instruction loads the next cycle.
- $0 handling: add $0,$0,$0 while WB_en=1, WB_Addr=0, WB_Data=99 -> no stall, Rs=Rt=0, Wr=0, SB unchanged.
- Set/clear collision: SB[5]=1, lw $5,-4($6) (imm=0xFFFC) with WB_en=1, WB_Addr=5 -> accepted that cycle, SB[5]=1 after the edge, Imm=0xFFFFFFFC.
